// File: rtl/bt_cmd_pkg.sv
// Shared definitions for the Bluetooth command receiver: move codes,
// the command validity mask and the UART receiver state encoding.
package bt_cmd_pkg;

  localparam logic [3:0] M_U = 4'd0;
  localparam logic [3:0] M_L = 4'd1;
  localparam logic [3:0] M_R = 4'd2;
  localparam logic [3:0] M_F = 4'd3;
  localparam logic [3:0] M_B = 4'd4;
  localparam logic [3:0] M_M = 4'd5;
  localparam logic [3:0] M_D = 4'd6;
  localparam logic [3:0] M_E = 4'd7;

  // Bits that must be zero in a move command: [7:6] reserved, [3] keeps codes in 0..7.
  localparam logic [7:0] CMD_MASK = 8'hC8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  function automatic logic is_cmd(input logic [7:0] b);
    return ((b & CMD_MASK) == 8'h00) && ({1'b0, b[2:0]} <= M_E) && ({1'b0, b[2:0]} >= M_U);
  endfunction

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver with a 2-flop input synchronizer. Emits each complete
// byte with a one-cycle data_valid strobe; frame_err flags framing errors and false starts.
module uart_rx_8n1
  import bt_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  // data_valid and frame_err are strobes with no ready: the consumer must
  // take data in the single cycle data_valid is high; data stays stable until the next frame.
  logic             rx_meta;
  logic             rx_s;
  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  assign data = shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          // Mid-start-bit check rejects glitches shorter than half a bit.
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state     <= IDLE;
              frame_err <= 1'b1;
            end else begin
              state <= DATA;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == FULL_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt == FULL_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state      <= IDLE;
              data_valid <= 1'b1;
            end else begin
              state     <= WAIT_IDLE;
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_IDLE: begin
          cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/bt_cmd_rx.sv
// Bluetooth command front end: validates received bytes as move commands,
// queues them and releases them to the move controller spaced by GAP_CYCLES.
module bt_cmd_rx
  import bt_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10416,
  parameter int FIFO_DEPTH   = 4,
  parameter int GAP_CYCLES   = 1100
) (
  input  logic                          clk,
  input  logic                          I_rst,
  input  logic                          I_rx,
  output logic [7:0]                    O_mode,
  output logic                          O_submit,
  output logic                          O_err,
  output logic                          O_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   O_pending
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int PEND_W = PTR_W + 1;
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ferr;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [GAP_W-1:0] gap;
  logic             cmd_ok;
  logic             push_req;
  logic             push;
  logic             pop;

  uart_rx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst       (I_rst),
    .rx        (I_rx),
    .data      (rx_data),
    .data_valid(rx_valid),
    .frame_err (rx_ferr)
  );

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  always_comb begin
    cmd_ok   = is_cmd(rx_data);
    push_req = rx_valid && cmd_ok;
    pop      = (gap == '0) && (O_pending != '0);
    push     = push_req && ((O_pending != PEND_W'(FIFO_DEPTH)) || pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or posedge I_rst) begin
    if (I_rst) begin
      O_mode     <= '0;
      O_submit   <= 1'b0;
      O_err      <= 1'b0;
      O_overflow <= 1'b0;
      O_pending  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      gap        <= '0;
    end else begin
      O_submit   <= pop;
      O_err      <= rx_ferr || (rx_valid && !cmd_ok);
      O_overflow <= push_req && !push;
      // Gap reloads on every release so the controller's act countdown always completes.
      if (pop) begin
        O_mode <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PTR_W'(1);
        gap    <= GAP_W'(GAP_CYCLES);
      end else if (gap != '0) begin
        gap <= gap - GAP_W'(1);
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   O_pending <= O_pending + PEND_W'(1);
        2'b01:   O_pending <= O_pending - PEND_W'(1);
        default: O_pending <= O_pending;
      endcase
    end
  end

endmodule

// File: doc/bt_cmd_rx.md
Name: bt_cmd_rx

Overview:
- Upstream feeder for the cube move controller: takes the Bluetooth module's UART serial stream and produces the controller's `I_mode[7:0]` / `I_bluetooth_submit` inputs.
- Receives 8N1 bytes and validates each byte as a move command.
- Queues valid commands in a small FIFO.
- Releases commands one at a time, spaced by at least GAP_CYCLES. The controller restarts its 1000-cycle act countdown on every submit, so closer spacing would silently lose moves.

Parameters:
- CLKS_PER_BIT, 10416: clk cycles per UART bit (100 MHz / 9600 baud); must be ≥ 4.
- FIFO_DEPTH, 4: command queue entries; power of two.
- GAP_CYCLES, 1100: minimum clk cycles between successive O_submit pulses; must exceed 1000.

Ports:
- clk  in  1  system clock
- I_rst  in  1  reset, asynchronous, active-high
- I_rx  in  1  UART RX from Bluetooth module, idle high, asynchronous to clk
- O_mode  out  8  last released command: [3:0] move code, [5:4] turn count
- O_submit  out  1  one-cycle pulse when O_mode has just been updated
- O_err  out  1  one-cycle pulse on invalid byte, framing error or false start
- O_overflow  out  1  one-cycle pulse when a valid byte is dropped because the FIFO is full
- O_pending  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset is asynchronous and active-high. While I_rst is high, all outputs read 0: O_mode=8'h00, O_submit/O_err/O_overflow=0, O_pending=0. The receiver goes to IDLE, the FIFO empties, the gap counter clears and the synchronizer flops load 1.
- Reset mid-frame discards the partial byte. After release the block waits for a fresh falling edge.
- I_rx passes through a 2-flop synchronizer (rx_s) before any use.
- Receiver FSM:
  - IDLE: rx_s==0 → START, bit counter cleared.
  - START: after CLKS_PER_BIT/2 cycles, sample rx_s. 1 → IDLE with O_err pulse (false start); 0 → DATA.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first; after bit 7 → STOP.
  - STOP: after CLKS_PER_BIT cycles, sample. 1 → byte complete, go to IDLE. 0 → framing error: O_err pulse, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s==1, then → IDLE.
- Command validity: byte[7:6]==2'b00 and byte[3]==0. These are move codes 0–7: U, L, R, F, B, M, D, E.
  - Invalid byte: O_err pulse in the cycle after the stop sample; nothing is pushed.
- Push: a valid byte is written into the FIFO on the clk edge after the stop sample.
  - If the FIFO is full and no pop happens in that cycle, the byte is dropped and O_overflow pulses for one cycle.
  - A pop in the same cycle frees a slot, so the push succeeds.
- Pacer:
  - gap counter loads GAP_CYCLES on each submit and decrements to 0; it holds at 0.
  - When gap==0 and O_pending>0 at a clock edge: pop the head, register it into O_mode, assert O_submit for exactly that next cycle.
  - No bypass: a byte arriving into an empty FIFO is popped one cycle after the push.
  - Latency: stop-bit sample edge → O_submit high at edge +2, provided gap==0.
- O_mode holds its value between submits and is never cleared except by reset. The downstream controller ORs O_mode[5:4] into its turn count continuously.
- O_pending counts 0..FIFO_DEPTH. Read and write pointers wrap modulo FIFO_DEPTH.
- Push and pop in the same cycle leave O_pending unchanged.
- Minimum spacing between O_submit rising edges is GAP_CYCLES+1 cycles.

Decomposition:
- Package bt_cmd_pkg holds:
  - move-code localparams: M_U=0, M_L=1, M_R=2, M_F=3, M_B=4, M_M=5, M_D=6, M_E=7;
  - the validity mask;
  - the receiver state encoding: IDLE, START, DATA, STOP, WAIT_IDLE.
- One sub-module: uart_rx_8n1. It contains the synchronizer and FSM and outputs byte[7:0], byte_valid (1 cycle) and frame_err (1 cycle).
- FIFO and pacer stay inline in bt_cmd_rx.

Test Plan:
- All tests use CLKS_PER_BIT=16 and GAP_CYCLES=1100.
- Send 0x12 → exactly one O_submit pulse; O_mode=8'h12 from that cycle onward; O_err=0; O_pending returns to 0.
- Send 0xC5, then 0x0A → two O_err pulses; no O_submit; O_mode stays 8'h00.
- Send 0x03 with stop bit driven 0, hold line low 40 cycles, release, then send 0x01 → one O_err pulse; no push for the first frame; then O_submit with O_mode=8'h01.
- Drive a 4-cycle low glitch on I_rx → O_err pulse from false start; FSM back in IDLE; a following 0x20 gives O_submit with O_mode=8'h20.
- Send 6 valid bytes 0x00–0x05 back-to-back (~160 cycles each):
  - 0x00 is submitted immediately;
  - 0x01–0x04 queue, O_pending peaks at 4;
  - 0x05 raises O_overflow;
  - submits follow at ≥1101-cycle spacing with O_mode 00, 01, 02, 03, 04.
- Assert I_rst for 3 cycles mid-DATA with 2 commands queued → outputs read 0 immediately (asynchronous); afterwards no submit occurs until a new full frame arrives.
